// File: rtl/fifo_protocol_monitor.sv
// fifo_protocol_monitor
//   Watches the handshake of NUM_CH independent FIFOs, keeps a shadow
//   occupancy per channel and flags protocol violations against it:
//     code 0 OVF      : write while full
//     code 1 UDF      : read while empty
//     code 2 FULL_MM  : full flag disagrees with shadow occupancy == DEPTH
//     code 3 EMPTY_MM : empty flag disagrees with shadow occupancy == 0
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   chk_en            : enables violation reporting (shadow always tracks)
//   clr               : clears sticky flags, counter and first-error capture
//   wr_en/rd_en       : per-channel requests as seen at the FIFO
//   full/empty        : per-channel FIFO status flags
//   occ               : per-channel shadow occupancy, channel i at [i*OCC_W +: OCC_W]
//   err_pulse         : one-cycle per-channel violation pulse
//   err_sticky        : sticky codes, bit i*4+k = code k of channel i
//   err_count         : saturating count of cycles with any violation
//   first_valid/ch/code : capture of the first violation since reset/clr
//   irq               : OR of all sticky bits
module fifo_protocol_monitor #(
    parameter int NUM_CH = 1,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      chk_en,
    input  logic                      clr,
    input  logic [NUM_CH-1:0]         wr_en,
    input  logic [NUM_CH-1:0]         rd_en,
    input  logic [NUM_CH-1:0]         full,
    input  logic [NUM_CH-1:0]         empty,
    output logic [NUM_CH*OCC_W-1:0]   occ,
    output logic [NUM_CH-1:0]         err_pulse,
    output logic [NUM_CH*4-1:0]       err_sticky,
    output logic [CNT_W-1:0]          err_count,
    output logic                      first_valid,
    output logic [CH_W-1:0]           first_ch,
    output logic [1:0]                first_code,
    output logic                      irq
);

    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    logic [NUM_CH*OCC_W-1:0] occ_q, occ_d;
    logic [NUM_CH-1:0]       pulse_q, pulse_d;
    logic [NUM_CH*4-1:0]     sticky_q, sticky_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    fvalid_q, fvalid_d;
    logic [CH_W-1:0]         fch_q, fch_d;
    logic [1:0]              fcode_q, fcode_d;
    logic                    irq_d;

    logic [3:0]              viol [NUM_CH];
    logic                    any_viol;
    logic [CH_W-1:0]         low_ch;
    logic [1:0]              low_code;

    always_comb begin
        occ_d    = occ_q;
        any_viol = 1'b0;
        low_ch   = '0;
        low_code = 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            logic [OCC_W-1:0] cur;
            logic             wr_acc, rd_acc;
            cur     = occ_q[i*OCC_W +: OCC_W];
            wr_acc  = wr_en[i] && !full[i];
            rd_acc  = rd_en[i] && !empty[i];
            viol[i] = {empty[i] != (cur == '0),
                       full[i]  != (cur == OCC_MAX),
                       rd_en[i] && empty[i],
                       wr_en[i] && full[i]};
            // Saturating update; simultaneous accepted write+read holds.
            if (wr_acc && !rd_acc && cur != OCC_MAX)
                occ_d[i*OCC_W +: OCC_W] = cur + 1'b1;
            else if (rd_acc && !wr_acc && cur != '0)
                occ_d[i*OCC_W +: OCC_W] = cur - 1'b1;
        end
        // Walk high-to-low so the lowest violating channel/code wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (viol[i] != 4'd0) begin
                any_viol = 1'b1;
                low_ch   = CH_W'(i);
                for (int k = 3; k >= 0; k--) begin
                    if (viol[i][k])
                        low_code = 2'(k);
                end
            end
        end
    end

    // Clear is applied first, then any same-cycle violation on top of it.
    always_comb begin
        sticky_d = clr ? '0 : sticky_q;
        count_d  = clr ? '0 : count_q;
        fvalid_d = clr ? 1'b0 : fvalid_q;
        fch_d    = clr ? '0 : fch_q;
        fcode_d  = clr ? 2'd0 : fcode_q;
        pulse_d  = '0;
        if (chk_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pulse_d[i]          = |viol[i];
                sticky_d[i*4 +: 4]  = sticky_d[i*4 +: 4] | viol[i];
            end
            if (any_viol) begin
                if (count_d != {CNT_W{1'b1}})
                    count_d = count_d + 1'b1;
                if (!fvalid_d) begin
                    fvalid_d = 1'b1;
                    fch_d    = low_ch;
                    fcode_d  = low_code;
                end
            end
        end
        irq_d = |sticky_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q    <= '0;
            pulse_q  <= '0;
            sticky_q <= '0;
            count_q  <= '0;
            fvalid_q <= 1'b0;
            fch_q    <= '0;
            fcode_q  <= 2'd0;
            irq      <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            fvalid_q <= fvalid_d;
            fch_q    <= fch_d;
            fcode_q  <= fcode_d;
            irq      <= irq_d;
        end
    end

    assign occ         = occ_q;
    assign err_pulse   = pulse_q;
    assign err_sticky  = sticky_q;
    assign err_count   = count_q;
    assign first_valid = fvalid_q;
    assign first_ch    = fch_q;
    assign first_code  = fcode_q;

endmodule

// File: tb/tb_fifo_protocol_monitor.sv
module tb_fifo_protocol_monitor;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 2;
    localparam int OCC_W  = 3;
    localparam int CH_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst_n, chk_en, clr;
    logic [NUM_CH-1:0]       wr_en, rd_en, full, empty;
    logic [NUM_CH*OCC_W-1:0] occ;
    logic [NUM_CH-1:0]       err_pulse;
    logic [NUM_CH*4-1:0]     err_sticky;
    logic [CNT_W-1:0]        err_count;
    logic                    first_valid;
    logic [CH_W-1:0]         first_ch;
    logic [1:0]              first_code;
    logic                    irq;

    int errors = 0;
    int checks = 0;

    fifo_protocol_monitor #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr),
        .wr_en(wr_en), .rd_en(rd_en), .full(full), .empty(empty),
        .occ(occ), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_count(err_count), .first_valid(first_valid), .first_ch(first_ch),
        .first_code(first_code), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with a violating pattern on the inputs: reset must win.
        rst_n = 0; chk_en = 1; clr = 1;
        wr_en = 4'b0001; rd_en = 4'b0000; full = 4'b0001; empty = 4'b1111;
        tick;
        chk("rst_occ",    32'(occ),         32'h0);
        chk("rst_pulse",  32'(err_pulse),   32'h0);
        chk("rst_sticky", 32'(err_sticky),  32'h0);
        chk("rst_count",  32'(err_count),   32'h0);
        chk("rst_fvalid", 32'(first_valid), 32'h0);
        chk("rst_fch",    32'(first_ch),    32'h0);
        chk("rst_fcode",  32'(first_code),  32'h0);
        chk("rst_irq",    32'(irq),         32'h0);

        // Fill channel 0 with correct flags, one simultaneous wr+rd inside.
        rst_n = 1; clr = 0; full = 4'b0000;
        tick;                                   // occ0 0->1
        empty = 4'b1110; tick;                  // 1->2
        rd_en = 4'b0001; tick;                  // wr+rd: stays 2
        chk("wr_rd_hold", 32'(occ[0 +: OCC_W]), 32'd2);
        rd_en = 4'b0000; tick;                  // 2->3
        tick;                                   // 3->4
        chk("fill_occ",   32'(occ[0 +: OCC_W]), 32'd4);
        chk("fill_count", 32'(err_count),       32'd0);
        chk("fill_pulse", 32'(err_pulse),       32'h0);

        // Fifth write with full=1: OVF
        full = 4'b0001; tick;
        chk("ovf_occ",    32'(occ[0 +: OCC_W]), 32'd4);
        chk("ovf_pulse",  32'(err_pulse),       32'h1);
        chk("ovf_sticky", 32'(err_sticky),      32'h0001);
        chk("ovf_count",  32'(err_count),       32'd1);
        chk("ovf_fvalid", 32'(first_valid),     32'd1);
        chk("ovf_fch",    32'(first_ch),        32'd0);
        chk("ovf_fcode",  32'(first_code),      32'd0);
        chk("ovf_irq",    32'(irq),             32'd1);
        wr_en = 4'b0000; tick;
        chk("ovf_pulse_end", 32'(err_pulse),  32'h0);
        chk("ovf_sticky_hold", 32'(err_sticky), 32'h0001);

        // Clear: error state goes, occupancy stays
        clr = 1; tick; clr = 0;
        chk("clr_count",  32'(err_count),       32'd0);
        chk("clr_sticky", 32'(err_sticky),      32'h0);
        chk("clr_fvalid", 32'(first_valid),     32'd0);
        chk("clr_irq",    32'(irq),             32'd0);
        chk("clr_occ",    32'(occ[0 +: OCC_W]), 32'd4);

        // UDF on channel 1
        rd_en = 4'b0010; tick;
        chk("udf_occ",    32'(occ[OCC_W +: OCC_W]), 32'd0);
        chk("udf_sticky", 32'(err_sticky),          32'h0020);
        chk("udf_irq",    32'(irq),                 32'd1);
        chk("udf_pulse",  32'(err_pulse),           32'h2);
        chk("udf_fch",    32'(first_ch),            32'd1);
        chk("udf_fcode",  32'(first_code),          32'd1);

        // EMPTY_MM on channel 2, first masked by chk_en=0
        rd_en = 4'b0000; clr = 1; tick; clr = 0;
        chk_en = 0; empty = 4'b1010; tick;
        chk("dis_pulse",  32'(err_pulse),  32'h0);
        chk("dis_count",  32'(err_count),  32'd0);
        chk("dis_sticky", 32'(err_sticky), 32'h0);
        chk_en = 1; tick;
        chk("emm_pulse",  32'(err_pulse),  32'h4);
        chk("emm_sticky", 32'(err_sticky), 32'h0800);
        chk("emm_count",  32'(err_count),  32'd1);
        chk("emm_fch",    32'(first_ch),   32'd2);
        chk("emm_fcode",  32'(first_code), 32'd3);

        // Channels 1 (OVF + FULL_MM) and 2 (EMPTY_MM) in one cycle
        empty = 4'b1110; clr = 1; tick; clr = 0;
        empty = 4'b1010; wr_en = 4'b0010; full = 4'b0011; tick;
        chk("multi_count",  32'(err_count),  32'd1);
        chk("multi_fch",    32'(first_ch),   32'd1);
        chk("multi_fcode",  32'(first_code), 32'd0);
        chk("multi_pulse",  32'(err_pulse),  32'h6);
        chk("multi_sticky", 32'(err_sticky), 32'h0850);

        // clr together with a channel-0 OVF
        empty = 4'b1110; wr_en = 4'b0001; full = 4'b0001; clr = 1; tick; clr = 0;
        chk("clrv_count",  32'(err_count),   32'd1);
        chk("clrv_fvalid", 32'(first_valid), 32'd1);
        chk("clrv_fch",    32'(first_ch),    32'd0);
        chk("clrv_fcode",  32'(first_code),  32'd0);
        chk("clrv_sticky", 32'(err_sticky),  32'h0001);

        // Saturate the 2-bit counter
        tick;
        chk("sat_count2", 32'(err_count), 32'd2);
        tick;
        chk("sat_count3", 32'(err_count), 32'd3);
        tick;
        chk("sat_hold", 32'(err_count), 32'd3);
        // Accepted write at occ==DEPTH (full wrongly low): occ must not wrap
        full = 4'b0000; tick;
        chk("occ_sat",     32'(occ[0 +: OCC_W]), 32'd4);
        chk("sat_hold2",   32'(err_count),       32'd3);
        chk("fullmm_stky", 32'(err_sticky),      32'h0005);

        // Reset mid-sequence while the violation persists
        rst_n = 0; tick;
        chk("rst2_occ",    32'(occ),         32'h0);
        chk("rst2_pulse",  32'(err_pulse),   32'h0);
        chk("rst2_sticky", 32'(err_sticky),  32'h0);
        chk("rst2_count",  32'(err_count),   32'd0);
        chk("rst2_fvalid", 32'(first_valid), 32'd0);
        chk("rst2_irq",    32'(irq),         32'd0);

        // First cycle after reset evaluates against occ=0
        rst_n = 1; empty = 4'b1111; tick;
        chk("post_occ",   32'(occ[0 +: OCC_W]), 32'd1);
        chk("post_count", 32'(err_count),       32'd0);
        wr_en = 4'b0000; rd_en = 4'b0001; empty = 4'b1110; tick;
        chk("post_rd_occ", 32'(occ[0 +: OCC_W]), 32'd0);
        chk("post_pulse",  32'(err_pulse),       32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
